pipe_stall_ctrl: RTL and testbench

- Central stall scheduler for the 5-stage MIPS pipeline (PC, IF, ID, EX, MEM, WB).
- Merges stall sources into the shared `StallBus` vector consumed by every stage register:
  - ID load-use request
  - EX multi-cycle divide
  - instruction-SRAM wait
  - data-SRAM wait
- Owns the divide-sequencing FSM and its watchdog counter.
- Keeps a stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl_pkg.sv | 38 +++
 rtl/pipe_stall_ctrl_div_seq_fsm.sv | 95 +++++++++
 rtl/pipe_stall_ctrl.sv | 87 ++++++++
 tb/tb_pipe_stall_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_pkg
// Shared definitions for the pipeline stall scheduler.
//   StallBus      : one hold bit per pipeline stage, index 0=PC ... 5=WB.
//   Stop / NoStop : values of a single StallBus bit.
//   STALL_*       : stall patterns, one per stall source. Each pattern holds
//                   the requesting stage and every stage in front of it.
//   div_state_e   : states of the divide sequencer.
// ---------------------------------------------------------------------------
package pipe_stall_ctrl_pkg;

  localparam int STALL_W = 6;

  typedef logic [STALL_W-1:0] StallBus;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // A stage that is held also holds every earlier stage. The first stage
  // that is not held loads a bubble, so the pipeline behind it keeps moving.
  localparam StallBus STALL_MEM  = 6'b011111;
  localparam StallBus STALL_EX   = 6'b001111;
  localparam StallBus STALL_ID   = 6'b000111;
  localparam StallBus STALL_IF   = 6'b000011;
  localparam StallBus STALL_NONE = 6'b000000;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_RUN  = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // True when at least one stage is held.
  function automatic logic any_stall(input StallBus s);
    return |s;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_div_seq_fsm.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_div_seq_fsm
// Divide sequencer. It holds the pipeline while a multi-cycle divide sits in
// EX, then releases EX for exactly one DONE cycle so the divide can retire.
// A watchdog forces the release if the divider never reports a result.
//
// Ports
//   clk            in   pipeline clock
//   resetn         in   synchronous active-low reset
//   div_start      in   a div/divu instruction is in EX (held high)
//   div_ready      in   divider result valid, single-cycle pulse
//   data_sram_wait in   MEM is held; a divide must not start or retire now
//   div_stall      out  divide requests the EX stall pattern this cycle
//   div_busy       out  sequencer is in RUN
//   div_timeout    out  sticky: watchdog has fired since reset
// ---------------------------------------------------------------------------
module pipe_stall_ctrl_div_seq_fsm
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_MAX = 40,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic resetn,
  input  logic div_start,
  input  logic div_ready,
  input  logic data_sram_wait,
  output logic div_stall,
  output logic div_busy,
  output logic div_timeout
);

  // Counter value in the last RUN cycle the watchdog allows.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_MAX - 1);

  div_state_e       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= DIV_IDLE;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          // While MEM is held the divide cannot advance anyway; the MEM
          // stall already covers EX, so wait here instead of counting.
          if (div_start && !data_sram_wait) begin
            state_reg <= DIV_RUN;
            cnt_reg   <= '0;
          end
        end

        DIV_RUN: begin
          // Saturate rather than wrap; the watchdog leaves RUN at CNT_LAST.
          if (cnt_reg != CNT_LAST) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          // A real result takes precedence over the watchdog, so a divide
          // that finishes on the very last allowed cycle is not a timeout.
          if (div_ready) begin
            state_reg <= DIV_DONE;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg   <= DIV_DONE;
            timeout_reg <= 1'b1;
          end
        end

        DIV_DONE: begin
          // div_start still belongs to the retiring instruction here, so it
          // is ignored. If MEM is held, EX cannot move either: stay until
          // the divide really leaves EX, otherwise it would start again.
          if (!data_sram_wait) begin
            state_reg <= DIV_IDLE;
          end
        end

        default: begin
          state_reg <= DIV_IDLE;
        end
      endcase
    end
  end

  // The stall must appear in the same cycle the divide reaches EX, so the
  // IDLE term uses div_start directly. DONE adds no stall, which lets the
  // divide retire.
  assign div_stall   = (state_reg == DIV_RUN) ||
                       ((state_reg == DIV_IDLE) && div_start);
  assign div_busy    = (state_reg == DIV_RUN);
  assign div_timeout = timeout_reg;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
// Central stall scheduler for the 5-stage pipeline. It merges the stall
// sources into one StallBus that every stage register consumes, sequences
// multi-cycle divides and counts the cycles spent stalled.
//
// Ports
//   clk              in   pipeline clock
//   resetn           in   synchronous active-low reset
//   stallreq_from_id in   load-use hazard detected in ID
//   ex_div_start     in   div/divu in EX (held high while it sits there)
//   ex_div_ready     in   divider result valid, single-cycle pulse
//   inst_sram_wait   in   instruction fetch still outstanding
//   data_sram_wait   in   MEM data access still outstanding
//   stall            out  per-stage hold vector, 0=PC ... 5=WB
//   div_busy         out  divide sequencer in RUN
//   div_timeout      out  sticky divide watchdog flag
//   stall_cycles     out  number of cycles with any stage held (wraps)
// ---------------------------------------------------------------------------
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_MAX = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stallreq_from_id,
  input  logic        ex_div_start,
  input  logic        ex_div_ready,
  input  logic        inst_sram_wait,
  input  logic        data_sram_wait,
  output StallBus     stall,
  output logic        div_busy,
  output logic        div_timeout,
  output logic [31:0] stall_cycles
);

  logic    div_stall;
  StallBus stall_sel;
  logic [31:0] stall_cycles_reg;

  pipe_stall_ctrl_div_seq_fsm #(
    .DIV_MAX (DIV_MAX),
    .CNT_W   (CNT_W)
  ) u_div_seq (
    .clk            (clk),
    .resetn         (resetn),
    .div_start      (ex_div_start),
    .div_ready      (ex_div_ready),
    .data_sram_wait (data_sram_wait),
    .div_stall      (div_stall),
    .div_busy       (div_busy),
    .div_timeout    (div_timeout)
  );

  // The deepest stalled stage wins. Each pattern is a superset of the ones
  // below it, so the highest-priority source also covers the shallower ones.
  always_comb begin
    stall_sel = STALL_NONE;
    if (data_sram_wait) begin
      stall_sel = STALL_MEM;
    end else if (div_stall) begin
      stall_sel = STALL_EX;
    end else if (stallreq_from_id) begin
      stall_sel = STALL_ID;
    end else if (inst_sram_wait) begin
      stall_sel = STALL_IF;
    end
  end

  // Map each selected bit onto the bus encoding used by the stage registers.
  for (genvar gi = 0; gi < STALL_W; gi++) begin : g_stall_bit
    assign stall[gi] = stall_sel[gi] ? Stop : NoStop;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cycles_reg <= '0;
    end else if (any_stall(stall_sel)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Directed scenarios followed by random stimulus, all checked against a
// behavioural model that tracks the divide as "running for N cycles" /
// "retiring" and computes the stall pattern from the source priorities.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  localparam int DIV_MAX = 40;
  localparam int CNT_W   = 6;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stallreq_from_id;
  logic        ex_div_start;
  logic        ex_div_ready;
  logic        inst_sram_wait;
  logic        data_sram_wait;
  logic [5:0]  stall;
  logic        div_busy;
  logic        div_timeout;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .DIV_MAX (DIV_MAX),
    .CNT_W   (CNT_W)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .stallreq_from_id (stallreq_from_id),
    .ex_div_start     (ex_div_start),
    .ex_div_ready     (ex_div_ready),
    .inst_sram_wait   (inst_sram_wait),
    .data_sram_wait   (data_sram_wait),
    .stall            (stall),
    .div_busy         (div_busy),
    .div_timeout      (div_timeout),
    .stall_cycles     (stall_cycles)
  );

  int n_vec     = 0;
  int n_err     = 0;
  int busy_seen = 0;

  // Reference model state.
  bit          m_running;
  bit          m_retiring;
  bit          m_timeout;
  int          m_elapsed;
  logic [31:0] m_cycles;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] model_stall();
    if (data_sram_wait) return 6'b011111;
    if (m_running || (!m_retiring && ex_div_start)) return 6'b001111;
    if (stallreq_from_id) return 6'b000111;
    if (inst_sram_wait) return 6'b000011;
    return 6'b000000;
  endfunction

  // One clock cycle: drive, check combinational and state outputs, clock,
  // then advance the model.
  task automatic step(input string tag, input bit rn, input bit id,
                      input bit st, input bit rd, input bit iw, input bit dw);
    logic [5:0] es;
    resetn           = rn;
    stallreq_from_id = id;
    ex_div_start     = st;
    ex_div_ready     = rd;
    inst_sram_wait   = iw;
    data_sram_wait   = dw;
    #1;
    es = model_stall();
    check_eq({tag, ".stall"},   {26'd0, stall},       {26'd0, es});
    check_eq({tag, ".busy"},    {31'd0, div_busy},    {31'd0, m_running});
    check_eq({tag, ".timeout"}, {31'd0, div_timeout}, {31'd0, m_timeout});
    check_eq({tag, ".cycles"},  stall_cycles,         m_cycles);
    if (div_busy === 1'b1) busy_seen++;
    $display("%s rn=%0b id=%0b st=%0b rd=%0b iw=%0b dw=%0b stall=%b busy=%0b to=%0b cyc=%0d",
             tag, rn, id, st, rd, iw, dw, stall, div_busy, div_timeout, stall_cycles);
    @(posedge clk);
    if (!rn) begin
      m_running  = 1'b0;
      m_retiring = 1'b0;
      m_timeout  = 1'b0;
      m_elapsed  = 0;
      m_cycles   = '0;
    end else begin
      if (es != 6'b0) m_cycles = m_cycles + 32'd1;
      if (m_retiring) begin
        if (!dw) m_retiring = 1'b0;
      end else if (m_running) begin
        m_elapsed++;
        if (rd) begin
          m_running  = 1'b0;
          m_retiring = 1'b1;
        end else if (m_elapsed == DIV_MAX) begin
          m_running  = 1'b0;
          m_retiring = 1'b1;
          m_timeout  = 1'b1;
        end
      end else if (st && !dw) begin
        m_running = 1'b1;
        m_elapsed = 0;
      end
    end
    #1;
  endtask

  initial begin
    m_running  = 1'b0;
    m_retiring = 1'b0;
    m_timeout  = 1'b0;
    m_elapsed  = 0;
    m_cycles   = '0;
    resetn = 1'b0; stallreq_from_id = 1'b1; ex_div_start = 1'b1;
    ex_div_ready = 1'b1; inst_sram_wait = 1'b1; data_sram_wait = 1'b1;
    @(posedge clk);
    #1;

    // Reset with every request asserted, then release quietly.
    step("rst0", 0, 1, 1, 1, 1, 1);
    step("rst1", 0, 1, 1, 1, 1, 1);
    step("idle", 1, 0, 0, 0, 0, 0);

    // Single load-use request.
    step("lu",   1, 1, 0, 0, 0, 0);
    step("lu_after", 1, 0, 0, 0, 0, 0);
    check_eq("lu.cycles_one", stall_cycles, 32'd1);

    // Divide with result on the 10th RUN cycle; start held through DONE.
    busy_seen = 0;
    step("div_start", 1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) step("div_run", 1, 0, 1, (i == 10), 0, 0);
    step("div_done", 1, 0, 1, 0, 0, 0);
    step("div_idle", 1, 0, 0, 0, 0, 0);
    check_eq("div.busy_cycles", busy_seen, 32'd10);

    // Divide that never completes: watchdog after DIV_MAX RUN cycles.
    busy_seen = 0;
    step("wd_start", 1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= DIV_MAX; i++) step("wd_run", 1, 0, 1, 0, 0, 0);
    step("wd_done", 1, 0, 1, 0, 0, 0);
    step("wd_idle", 1, 0, 0, 0, 0, 0);
    check_eq("wd.busy_cycles", busy_seen, DIV_MAX);
    check_eq("wd.timeout_set", {31'd0, div_timeout}, 32'd1);

    // A normal divide afterwards leaves the timeout flag set.
    step("div2_start", 1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) step("div2_run", 1, 0, 1, (i == 3), 0, 0);
    step("div2_done", 1, 0, 1, 0, 0, 0);
    step("div2_idle", 1, 0, 0, 0, 0, 0);
    check_eq("div2.timeout_sticky", {31'd0, div_timeout}, 32'd1);

    // MEM wait and load-use overlapping a divide.
    step("ov_start", 1, 0, 1, 0, 0, 0);
    step("ov_run", 1, 0, 1, 0, 0, 0);
    step("ov_run", 1, 0, 1, 0, 0, 0);
    step("ov_mem", 1, 1, 1, 0, 0, 1);
    step("ov_ex",  1, 1, 1, 0, 0, 0);
    step("ov_rdy", 1, 1, 1, 1, 0, 0);
    step("ov_done_lu", 1, 1, 1, 0, 0, 0);
    step("ov_idle", 1, 0, 0, 0, 0, 0);

    // Reset in the 5th RUN cycle, then a stray ready pulse.
    step("rr_start", 1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step("rr_run", 1, 0, 1, 0, 0, 0);
    step("rr_reset", 0, 0, 1, 0, 0, 0);
    step("rr_stray", 1, 0, 0, 1, 0, 0);
    check_eq("rr.busy_low", {31'd0, div_busy}, 32'd0);
    step("rr_idle", 1, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step("rnd",
           ($urandom_range(63) != 0),
           ($urandom_range(5) == 0),
           ($urandom_range(2) == 0),
           ($urandom_range(7) == 0),
           ($urandom_range(3) == 0),
           ($urandom_range(5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
